// File: rtl/uart_rx_packet_parser_if.sv
// uart_rx_packet_parser_if: RX FIFO pop side, payload stream and packet status of the parser
interface uart_rx_packet_parser_if;
    logic       fifo_empty;
    logic [7:0] fifo_rd_data;
    logic       fifo_rd_en;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       pkt_done;
    logic       pkt_err;
    logic [1:0] err_code;
    logic [7:0] pkt_len;
    modport master (
        output fifo_empty, fifo_rd_data, out_ready,
        input  fifo_rd_en, out_valid, out_data, out_last, pkt_done, pkt_err, err_code, pkt_len
    );
    modport slave (
        input  fifo_empty, fifo_rd_data, out_ready,
        output fifo_rd_en, out_valid, out_data, out_last, pkt_done, pkt_err, err_code, pkt_len
    );
endinterface

// File: rtl/uart_rx_packet_parser.sv
// uart_rx_packet_parser: pops RX FIFO bytes, parses SYNC/LEN/payload/CHK frames, streams payload
// Optional inter-byte timeout enabled by defining UART_PKT_TIMEOUT_EN.
module uart_rx_packet_parser #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_LEN   = 16
`ifdef UART_PKT_TIMEOUT_EN
    ,
    parameter int         TIMEOUT_CYCLES = 10000
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_rx_packet_parser_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, CHK} state_t;
    state_t     state_q, state_d;
    logic       rd_pending_q, rd_en;
    logic [7:0] cnt_q, cnt_d, len_q, len_d, chk_q, chk_d;
    logic       out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [7:0] out_data_q, out_data_d, pkt_len_q, pkt_len_d;
    logic       pkt_done_q, pkt_done_d, pkt_err_q, pkt_err_d;
    logic [1:0] err_code_q, err_code_d;
    logic [7:0] b;
`ifdef UART_PKT_TIMEOUT_EN
    logic [31:0] idle_q, idle_d;
    logic        stalled;
`endif
    assign b     = bus.fifo_rd_data;
    assign rd_en = !bus.fifo_empty && !rd_pending_q && (!out_valid_q || bus.out_ready);
    assign bus.fifo_rd_en = rd_en;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_last   = out_last_q;
    assign bus.pkt_done   = pkt_done_q;
    assign bus.pkt_err    = pkt_err_q;
    assign bus.err_code   = err_code_q;
    assign bus.pkt_len    = pkt_len_q;
`ifdef UART_PKT_TIMEOUT_EN
    assign stalled = (state_q != IDLE) && bus.fifo_empty && !rd_pending_q;
`endif
    // Frame FSM: advances only when a popped byte arrives; handshake frees the output slot
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        chk_d       = (state_q == IDLE) ? 8'h00 : chk_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        pkt_done_d  = 1'b0;
        pkt_err_d   = 1'b0;
        err_code_d  = err_code_q;
        pkt_len_d   = pkt_len_q;
        if (rd_pending_q) begin
            unique case (state_q)
                IDLE: state_d = (b == SYNC_BYTE) ? LEN : IDLE;
                LEN: begin
                    if (b == 8'h00 || b > 8'(MAX_LEN)) begin
                        pkt_err_d  = 1'b1;
                        err_code_d = 2'd1;
                        state_d    = IDLE;
                    end else begin
                        cnt_d   = b;
                        len_d   = b;
                        chk_d   = b;
                        state_d = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    out_data_d  = b;
                    out_valid_d = 1'b1;
                    out_last_d  = (cnt_q == 8'd1);
                    chk_d       = chk_q ^ b;
                    cnt_d       = cnt_q - 8'd1;
                    state_d     = (cnt_q == 8'd1) ? CHK : PAYLOAD;
                end
                CHK: begin
                    pkt_len_d  = len_q;
                    pkt_done_d = (b == chk_q);
                    pkt_err_d  = (b != chk_q);
                    err_code_d = (b == chk_q) ? err_code_q : 2'd2;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
`ifdef UART_PKT_TIMEOUT_EN
        idle_d = (state_q == IDLE || rd_pending_q) ? 32'd0 : stalled ? idle_q + 32'd1 : idle_q;
        if (stalled && idle_q == 32'(TIMEOUT_CYCLES - 1)) begin
            state_d    = IDLE;
            pkt_err_d  = 1'b1;
            err_code_d = 2'd3;
            idle_d     = 32'd0;
        end
`endif
    end
    // State and output registers; reset drops any held byte and returns to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rd_pending_q <= 1'b0;
            cnt_q        <= 8'h00;
            len_q        <= 8'h00;
            chk_q        <= 8'h00;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            out_last_q   <= 1'b0;
            pkt_done_q   <= 1'b0;
            pkt_err_q    <= 1'b0;
            err_code_q   <= 2'd0;
            pkt_len_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            rd_pending_q <= rd_en;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            chk_q        <= chk_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            pkt_done_q   <= pkt_done_d;
            pkt_err_q    <= pkt_err_d;
            err_code_q   <= err_code_d;
            pkt_len_q    <= pkt_len_d;
        end
    end
`ifdef UART_PKT_TIMEOUT_EN
    // Inter-byte idle counter, ignores backpressure stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) idle_q <= 32'd0;
        else     idle_q <= idle_d;
    end
`endif
endmodule

// File: tb/tb_uart_rx_packet_parser.sv
// tb_uart_rx_packet_parser: table-driven frame vectors plus backpressure, latency, timeout and reset sequences
module tb_uart_rx_packet_parser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    uart_rx_packet_parser_if ifc();
`ifdef UART_PKT_TIMEOUT_EN
    uart_rx_packet_parser #(.TIMEOUT_CYCLES(200)) dut (.clk(clk), .rst(rst), .bus(ifc));
`else
    uart_rx_packet_parser dut (.clk(clk), .rst(rst), .bus(ifc));
`endif
    logic [7:0] mem [1024];
    int wr = 0;
    int rd = 0;
    assign ifc.fifo_empty = (wr == rd);
    always @(posedge clk) begin
        if (ifc.fifo_rd_en) begin
            ifc.fifo_rd_data <= mem[rd[9:0]];
            rd <= rd + 1;
        end
    end
    logic [8:0] cap [$];
    int n_done = 0;
    int n_err = 0;
    int n_both = 0;
    int n_stall = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (ifc.out_valid && ifc.out_ready) cap.push_back({ifc.out_last, ifc.out_data});
            if (ifc.pkt_done) n_done <= n_done + 1;
            if (ifc.pkt_err) n_err <= n_err + 1;
            if (ifc.pkt_done && ifc.pkt_err) n_both <= n_both + 1;
            if (ifc.out_valid && !ifc.out_ready && ifc.fifo_rd_en) n_stall <= n_stall + 1;
        end
    end
    int n_chk = 0;
    int n_fail = 0;
    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask
    task automatic push(input logic [7:0] v);
        mem[wr[9:0]] = v;
        wr = wr + 1;
    endtask
    task automatic settle(input string nm);
        int k = 0;
        while (!(wr == rd && !ifc.out_valid) && k < 500) begin
            @(negedge clk);
            k++;
        end
        check({nm, " settle"}, int'(k < 500), 1);
        repeat (4) @(negedge clk);
    endtask
    task automatic wait_valid(input string nm);
        int k = 0;
        while (!ifc.out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({nm, " wait out_valid"}, int'(ifc.out_valid), 1);
    endtask
    task automatic push_case1();
        push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h03);
    endtask
    task automatic check_case1(input string nm, input int d0);
        check({nm, " count"}, cap.size(), 3);
        check({nm, " byte0"}, cap.size() > 0 ? int'(cap[0]) : -1, 9'h011);
        check({nm, " byte1"}, cap.size() > 1 ? int'(cap[1]) : -1, 9'h022);
        check({nm, " byte2+last"}, cap.size() > 2 ? int'(cap[2]) : -1, 9'h133);
        check({nm, " pkt_done"}, n_done - d0, 1);
        check({nm, " pkt_len"}, int'(ifc.pkt_len), 3);
    endtask
    task automatic check_zero(input string nm);
        check({nm, " out_valid"}, int'(ifc.out_valid), 0);
        check({nm, " out_data"}, int'(ifc.out_data), 0);
        check({nm, " out_last"}, int'(ifc.out_last), 0);
        check({nm, " pkt_done"}, int'(ifc.pkt_done), 0);
        check({nm, " pkt_err"}, int'(ifc.pkt_err), 0);
        check({nm, " err_code"}, int'(ifc.err_code), 0);
        check({nm, " pkt_len"}, int'(ifc.pkt_len), 0);
    endtask
    typedef struct {
        logic [159:0] ib;
        int           ni;
        logic [127:0] ob;
        int           no;
        int           done;
        int           err;
        int           code;
        int           len;
    } vec_t;
    vec_t v [8];
    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
    initial begin
        int d0, e0, s0, k;
        v[0] = '{160'hA5_03_11_22_33_03, 6, 128'h11_22_33, 3, 1, 0, 0, 3};
        v[1] = '{160'h00_FF_A5_01_5A_5B, 6, 128'h5A, 1, 1, 0, 0, 1};
        v[2] = '{160'hA5_02_10_20_00, 5, 128'h10_20, 2, 0, 1, 2, 2};
        v[3] = '{160'hA5_00, 2, 128'h0, 0, 0, 1, 1, 2};
        v[4] = '{160'hA5_11, 2, 128'h0, 0, 0, 1, 1, 2};
        v[5] = '{160'hA5_03_11_22_33_03, 6, 128'h11_22_33, 3, 1, 0, 1, 3};
        v[6] = '{160'hA5_A5, 2, 128'h0, 0, 0, 1, 1, 3};
        v[7] = '{160'hA5_10_01_02_03_04_05_06_07_08_09_0A_0B_0C_0D_0E_0F_10_00, 19,
                 128'h01_02_03_04_05_06_07_08_09_0A_0B_0C_0D_0E_0F_10, 16, 1, 0, 1, 16};
        ifc.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        check("reset fifo_rd_en", int'(ifc.fifo_rd_en), 0);
        rst = 1'b0;
        @(negedge clk);
        for (int t = 0; t < 8; t++) begin
            cap.delete();
            d0 = n_done;
            e0 = n_err;
            for (int i = 0; i < v[t].ni; i++) push(8'(v[t].ib >> (8 * (v[t].ni - 1 - i))));
            settle($sformatf("v%0d", t));
            check($sformatf("v%0d count", t), cap.size(), v[t].no);
            for (int i = 0; i < v[t].no; i++) begin
                check($sformatf("v%0d data%0d", t, i), i < cap.size() ? int'(cap[i][7:0]) : -1,
                      int'(8'(v[t].ob >> (8 * (v[t].no - 1 - i)))));
                check($sformatf("v%0d last%0d", t, i), i < cap.size() ? int'(cap[i][8]) : -1,
                      int'(i == v[t].no - 1));
            end
            check($sformatf("v%0d pkt_done", t), n_done - d0, v[t].done);
            check($sformatf("v%0d pkt_err", t), n_err - e0, v[t].err);
            check($sformatf("v%0d err_code", t), int'(ifc.err_code), v[t].code);
            check($sformatf("v%0d pkt_len", t), int'(ifc.pkt_len), v[t].len);
        end
        ifc.out_ready = 1'b0;
        cap.delete();
        d0 = n_done;
        s0 = n_stall;
        push_case1();
        wait_valid("bp");
        repeat (50) @(negedge clk);
        check("bp held data", int'(ifc.out_data), 8'h11);
        check("bp held valid", int'(ifc.out_valid), 1);
        check("bp rd_en while held", n_stall - s0, 0);
        check("bp nothing taken", cap.size(), 0);
        ifc.out_ready = 1'b1;
        settle("bp");
        check_case1("bp", d0);
        push(8'hA5);
        push(8'h01);
        settle("lat hdr");
        d0 = n_done;
        push(8'h5A);
        #1;
        check("lat rd_en cycle0", int'(ifc.fifo_rd_en), 1);
        @(negedge clk);
        check("lat valid cycle1", int'(ifc.out_valid), 0);
        @(negedge clk);
        check("lat valid cycle2", int'(ifc.out_valid), 1);
        check("lat data cycle2", int'(ifc.out_data), 8'h5A);
        check("lat last cycle2", int'(ifc.out_last), 1);
        push(8'h5B);
        settle("lat");
        check("lat pkt_done", n_done - d0, 1);
        check("lat pkt_len", int'(ifc.pkt_len), 1);
        push(8'hA5);
        push(8'h02);
        push(8'h10);
        settle("tmo");
        e0 = n_err;
        d0 = n_done;
        repeat (250) @(negedge clk);
`ifdef UART_PKT_TIMEOUT_EN
        check("tmo pkt_err", n_err - e0, 1);
        check("tmo err_code", int'(ifc.err_code), 3);
        cap.delete();
        push_case1();
        settle("tmo next");
        check_case1("tmo next", d0);
`else
        check("no tmo pkt_err", n_err - e0, 0);
        check("no tmo err_code", int'(ifc.err_code), 1);
        push(8'h20);
        push(8'h32);
        settle("no tmo");
        check("no tmo pkt_done", n_done - d0, 1);
        check("no tmo pkt_len", int'(ifc.pkt_len), 2);
`endif
        ifc.out_ready = 1'b0;
        push(8'hA5);
        push(8'h03);
        push(8'h11);
        wait_valid("rst");
        rst = 1'b1;
        @(negedge clk);
        check_zero("mid rst");
        rst = 1'b0;
        ifc.out_ready = 1'b1;
        cap.delete();
        d0 = n_done;
        k = 0;
        push_case1();
        settle("post rst");
        check_case1("post rst", d0);
        check("done/err overlap", n_both, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
